mini_calculo_seq: RTL and testbench
===================================

Name: mini_calculo_seq

Overview:
- Parametrised successor to the 4-bit mini calculator.
- Accepts a stream of keypad codes: multi-digit decimal operands, an operator key, and an execute key.
- Computes WIDTH-bit unsigned results and flags arithmetic and entry errors on an LED.
- Stores each result in an NREGS-deep circular history register file that can be read back.
- Sits between the debounced keypad front-end and the display/LED drivers on the board top.

Parameters:
- WIDTH, 8: operand/result width in bits (unsigned).
- NREGS, 8: history depth in entries (power of two, at least 2).
- AW, $clog2(NREGS): history address width (derived; do not override).

Ports:
- clk_pi, input, 1: system clock, rising edge.
- rst_pi, input, 1: asynchronous, active-high reset.
- teclado_pi, input, 4: key code; sampled only when key_valid_pi=1.
- key_valid_pi, input, 1: one-cycle strobe per key press (debounced upstream).
- switch_pi, input, 1: chain mode; 1 = an operator key after a result reuses that result as operand A.
- rd_addr_pi, input, AW: history read address.
- display_po, output, WIDTH: value to display.
- led_op_po, output, 1: an operator is latched and operand B entry is pending.
- led_error_po, output, 1: error state.
- rd_data_po, output, WIDTH: history read data.
- hist_count_po, output, AW+1: number of valid history entries (saturates at NREGS).

Behaviour:
- Decided: one clock; reset is asynchronous and active-high (rst_pi).
- Key codes:
  - 0x0-0x9: digits.
  - 0xA: execute (=).
  - 0xB: ADD.
  - 0xC: SUB.
  - 0xD: AND.
  - 0xE: OR.
  - 0xF: CLEAR.
- Keys are sampled on the rising edge with key_valid_pi=1. Effects are visible on outputs the next cycle (latency 1). Without key_valid_pi, state holds.
- Reset values:
  - State S_OPA; acc_a, acc_b, result = 0.
  - b_has_digit = 0.
  - display_po = 0; led_op_po = 0; led_error_po = 0.
  - History cleared; wr_ptr = 0; hist_count_po = 0; rd_data_po = 0.
- Reset mid-operation aborts all state immediately.
- Digit entry: acc <= acc*10 + d, computed at WIDTH+4 bits. If the value exceeds 2^WIDTH-1, go to S_ERROR.
- FSM states: S_OPA, S_OPB, S_RESULT, S_ERROR. CLEAR in any state returns to S_OPA with all accumulators zeroed; history is kept.
- S_OPA:
  - Digit: accumulates into acc_a.
  - Operator key: latches the op, sets acc_b=0 and b_has_digit=0, goes to S_OPB.
  - Execute: ignored.
  - display_po = acc_a.
- S_OPB:
  - Digit: accumulates into acc_b and sets b_has_digit.
  - Operator key with b_has_digit=0: replaces the latched op.
  - Operator key with b_has_digit=1: ignored.
  - Execute with b_has_digit=0: go to S_ERROR.
  - Execute with b_has_digit=1: compute, go to S_RESULT, write the result to history.
  - display_po = acc_b if b_has_digit, else acc_a.
  - led_op_po = 1 only in S_OPB.
- Arithmetic:
  - ADD carry out of WIDTH: error.
  - SUB with acc_b > acc_a: error.
  - AND/OR never error.
  - An erroring execute writes nothing to history.
- S_RESULT:
  - display_po = result.
  - Digit: acc_a = d, go to S_OPA.
  - Operator key with switch_pi=1: acc_a = result, latch op, go to S_OPB.
  - Operator key with switch_pi=0: ignored.
  - Execute: ignored.
- S_ERROR:
  - led_error_po = 1; display_po = 0.
  - Every key except CLEAR is ignored.
- History write: the write slot is wr_ptr, which then increments with wrap-around to 0. Once full, the oldest entry is overwritten. hist_count_po increments and saturates at NREGS.
- History read:
  - rd_data_po is registered, one-cycle latency.
  - Read and write to the same address in the same cycle returns the old data.
  - An address at or above hist_count_po returns 0.
- All outputs are registered or decoded from registered state only; no combinational path from teclado_pi to outputs.

Decomposition:
- calc_pkg:
  - Key-code localparams (KEY_EXEC=4'hA, KEY_ADD=4'hB, KEY_SUB=4'hC, KEY_AND=4'hD, KEY_OR=4'hE, KEY_CLR=4'hF).
  - op_e enum {OP_ADD, OP_SUB, OP_AND, OP_OR}.
  - state_e enum {S_OPA, S_OPB, S_RESULT, S_ERROR}.
- Sub-module calc_history_rf: parametrised WIDTH/NREGS circular register file with write pointer, count and registered read port.
- The FSM, ALU and digit accumulator stay in mini_calculo_seq.

Test Plan:
- WIDTH=8, switch_pi=1; keys 2,B,3,A, each a one-cycle strobe → led_op_po=1 after B; display_po=3 after 3; after A display_po=5, led_op_po=0, hist_count_po=1, rd_addr_pi=0 gives rd_data_po=5 one cycle later.
- Keys 2,5,0,B,1,0,A → 250+10 overflows → led_error_po=1, display_po=0; further digits ignored; F → led_error_po=0, display_po=0, state S_OPA; hist_count_po unchanged.
- Keys 2,5,6 → 256 exceeds 255 on the third digit → led_error_po=1. Separately, keys 3,C,5,A → borrow → led_error_po=1. Keys 7,B,A (empty B) → led_error_po=1.
- Chain mode: 4,B,3,A (display 7), then D,6,A → display_po=6 (7&6). Repeat with switch_pi=0: D after the result is ignored, led_op_po stays 0, display_po stays 7.
- Keys 5,B,C,2,A → operator replaced before B digits → result 3. Key strobe with key_valid_pi=0 → no change.
- NREGS=8, nine executes producing 1..9 → hist_count_po=8; entry 0 reads 9 and entry 1 reads 2. Assert rst_pi mid-entry (after 1,B) → all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, operator and FSM state types
// for the sequential mini calculator.
package calc_pkg;

   localparam logic [3:0] KEY_EXEC = 4'hA;
   localparam logic [3:0] KEY_ADD  = 4'hB;
   localparam logic [3:0] KEY_SUB  = 4'hC;
   localparam logic [3:0] KEY_AND  = 4'hD;
   localparam logic [3:0] KEY_OR   = 4'hE;
   localparam logic [3:0] KEY_CLR  = 4'hF;

   typedef enum logic [1:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR
   } op_e;

   typedef enum logic [1:0] {
      S_OPA, S_OPB, S_RESULT, S_ERROR
   } state_e;

   // Operator keys are contiguous, so the offset from ADD is the op code
   function automatic op_e key_to_op(input logic [3:0] key);
      return op_e'(2'(key - KEY_ADD));
   endfunction

endpackage

// File: rtl/mini_calculo_seq_if.sv
// Keypad, display and history read bundle between
// the board front-end and the calculator core.
interface mini_calculo_seq_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 8
);
   localparam int AW = $clog2(NREGS);

   logic [3:0]       teclado_pi;
   logic             key_valid_pi;
   logic             switch_pi;
   logic [AW-1:0]    rd_addr_pi;
   logic [WIDTH-1:0] display_po;
   logic             led_op_po;
   logic             led_error_po;
   logic [WIDTH-1:0] rd_data_po;
   logic [AW:0]      hist_count_po;

   modport master (
      output teclado_pi, key_valid_pi, switch_pi, rd_addr_pi,
      input  display_po, led_op_po, led_error_po,
      input  rd_data_po, hist_count_po
   );

   modport slave (
      input  teclado_pi, key_valid_pi, switch_pi, rd_addr_pi,
      output display_po, led_op_po, led_error_po,
      output rd_data_po, hist_count_po
   );

endinterface

// File: rtl/calc_history_rf.sv
// Circular result history: write pointer, saturating
// entry count and a registered, bounds-checked read port.
module calc_history_rf #(
   parameter int WIDTH = 8,
   parameter int NREGS = 8,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [NREGS];
   logic [AW-1:0]    wr_ptr;

   // Read uses pre-write contents and count, giving old data on collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if ({1'b0, rd_addr} < count) rd_data <= mem[rd_addr];
         else                         rd_data <= '0;
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
            if (count != (AW+1)'(NREGS)) count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mini_calculo_seq.sv
// Keypad-driven calculator: decimal entry, 4-op ALU,
// error handling and result history.
module mini_calculo_seq
   import calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 8,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk_pi,
   input  logic             rst_pi,
   mini_calculo_seq_if.slave bus
);

   state_e           state, state_n;
   op_e              op, op_n;
   logic [WIDTH-1:0] acc_a, acc_a_n;
   logic [WIDTH-1:0] acc_b, acc_b_n;
   logic [WIDTH-1:0] result, result_n;
   logic             b_has, b_has_n;
   logic             wr_en;

   logic [3:0]       key;
   logic             is_digit, is_op;
   logic [WIDTH-1:0] dig_src;
   logic [WIDTH+3:0] dig_wide;
   logic             dig_ovf;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_err;

   assign key      = bus.teclado_pi;
   assign is_digit = key <= 4'd9;
   assign is_op    = key inside {KEY_ADD, KEY_SUB, KEY_AND, KEY_OR};

   // Wide enough that acc*10+9 cannot wrap before the range check
   assign dig_src  = (state == S_OPB) ? acc_b : acc_a;
   assign dig_wide = {4'b0, dig_src} * (WIDTH+4)'(10)
                   + {WIDTH'(0), key};
   assign dig_ovf  = |dig_wide[WIDTH+3:WIDTH];

   assign sum = {1'b0, acc_a} + {1'b0, acc_b};

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      unique case (op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_err = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res = acc_a - acc_b;
            alu_err = acc_b > acc_a;
         end
         OP_AND: alu_res = acc_a & acc_b;
         OP_OR:  alu_res = acc_a | acc_b;
         default: ;
      endcase
   end

   always_ff @(posedge clk_pi or posedge rst_pi) begin
      if (rst_pi) begin
         state  <= S_OPA;
         op     <= OP_ADD;
         acc_a  <= '0;
         acc_b  <= '0;
         result <= '0;
         b_has  <= 1'b0;
      end else begin
         state  <= state_n;
         op     <= op_n;
         acc_a  <= acc_a_n;
         acc_b  <= acc_b_n;
         result <= result_n;
         b_has  <= b_has_n;
      end
   end

   always_comb begin
      state_n  = state;
      op_n     = op;
      acc_a_n  = acc_a;
      acc_b_n  = acc_b;
      result_n = result;
      b_has_n  = b_has;
      wr_en    = 1'b0;
      if (bus.key_valid_pi) begin
         if (key == KEY_CLR) begin
            state_n  = S_OPA;
            acc_a_n  = '0;
            acc_b_n  = '0;
            result_n = '0;
            b_has_n  = 1'b0;
         end else begin
            unique case (state)
               S_OPA: begin
                  if (is_digit) begin
                     if (dig_ovf) state_n = S_ERROR;
                     else acc_a_n = dig_wide[WIDTH-1:0];
                  end else if (is_op) begin
                     op_n    = key_to_op(key);
                     acc_b_n = '0;
                     b_has_n = 1'b0;
                     state_n = S_OPB;
                  end
               end
               S_OPB: begin
                  if (is_digit) begin
                     if (dig_ovf) state_n = S_ERROR;
                     else begin
                        acc_b_n = dig_wide[WIDTH-1:0];
                        b_has_n = 1'b1;
                     end
                  end else if (is_op) begin
                     if (!b_has) op_n = key_to_op(key);
                  end else if (key == KEY_EXEC) begin
                     if (!b_has || alu_err) state_n = S_ERROR;
                     else begin
                        result_n = alu_res;
                        wr_en    = 1'b1;
                        state_n  = S_RESULT;
                     end
                  end
               end
               S_RESULT: begin
                  if (is_digit) begin
                     acc_a_n = {{(WIDTH-4){1'b0}}, key};
                     state_n = S_OPA;
                  end else if (is_op && bus.switch_pi) begin
                     acc_a_n = result;
                     op_n    = key_to_op(key);
                     acc_b_n = '0;
                     b_has_n = 1'b0;
                     state_n = S_OPB;
                  end
               end
               S_ERROR: ;
               default: state_n = S_ERROR;
            endcase
         end
      end
   end

   always_comb begin
      bus.display_po = '0;
      unique case (state)
         S_OPA:    bus.display_po = acc_a;
         S_OPB:    bus.display_po = b_has ? acc_b : acc_a;
         S_RESULT: bus.display_po = result;
         S_ERROR:  bus.display_po = '0;
         default:  bus.display_po = '0;
      endcase
   end

   assign bus.led_op_po    = state == S_OPB;
   assign bus.led_error_po = state == S_ERROR;

   calc_history_rf #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_hist (
      .clk     (clk_pi),
      .rst     (rst_pi),
      .wr_en   (wr_en),
      .wr_data (alu_res),
      .rd_addr (bus.rd_addr_pi),
      .rd_data (bus.rd_data_po),
      .count   (bus.hist_count_po)
   );

endmodule

// File: tb/tb_mini_calculo_seq.sv
// Scoreboard bench: key sequences and random keys against
// an arithmetic reference model of the calculator.
module tb_mini_calculo_seq;

   localparam int MAXV  = 255;
   localparam int DEPTH = 8;
   localparam int MA = 0, MB = 1, MR = 2, ME = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mini_calculo_seq_if #(.WIDTH(8), .NREGS(8)) bus ();

   mini_calculo_seq #(.WIDTH(8), .NREGS(8)) dut (
      .clk_pi (clk),
      .rst_pi (rst),
      .bus    (bus)
   );

   typedef struct {
      int disp;
      int lop;
      int lerr;
      int cnt;
      int rd;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   int m_mode, m_a, m_b, m_r, m_op;
   bit m_bh;
   int hist[$];

   function automatic int hist_count();
      return (hist.size() > DEPTH) ? DEPTH : hist.size();
   endfunction

   // Address i holds the most recent result whose write index is i mod DEPTH
   function automatic int hist_read(int addr);
      int idx;
      if (addr >= hist_count()) return 0;
      idx = addr + DEPTH * ((hist.size() - 1 - addr) / DEPTH);
      return hist[idx];
   endfunction

   function automatic int exp_display();
      case (m_mode)
         MA: return m_a;
         MB: return m_bh ? m_b : m_a;
         MR: return m_r;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = MA; m_a = 0; m_b = 0; m_r = 0; m_op = 11; m_bh = 0;
      hist.delete();
   endtask

   task automatic model_step(input int k, input bit sw);
      bit dig, opk, err;
      int t;
      dig = (k <= 9);
      opk = (k >= 11 && k <= 14);
      if (k == 15) begin
         m_mode = MA; m_a = 0; m_b = 0; m_r = 0; m_bh = 0;
         return;
      end
      case (m_mode)
         MA: begin
            if (dig) begin
               t = m_a * 10 + k;
               if (t > MAXV) m_mode = ME; else m_a = t;
            end else if (opk) begin
               m_op = k; m_b = 0; m_bh = 0; m_mode = MB;
            end
         end
         MB: begin
            if (dig) begin
               t = m_b * 10 + k;
               if (t > MAXV) m_mode = ME;
               else begin m_b = t; m_bh = 1; end
            end else if (opk) begin
               if (!m_bh) m_op = k;
            end else if (k == 10) begin
               err = 0;
               t = 0;
               case (m_op)
                  11: begin t = m_a + m_b; err = t > MAXV; end
                  12: begin t = m_a - m_b; err = m_b > m_a; end
                  13: t = m_a & m_b;
                  default: t = m_a | m_b;
               endcase
               if (!m_bh || err) m_mode = ME;
               else begin
                  m_r = t; hist.push_back(t); m_mode = MR;
               end
            end
         end
         MR: begin
            if (dig) begin
               m_a = k; m_mode = MA;
            end else if (opk && sw) begin
               m_a = m_r; m_op = k; m_b = 0; m_bh = 0; m_mode = MB;
            end
         end
         default: ;
      endcase
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input int key, input bit valid, input int rd);
      exp_t e;
      @(negedge clk);
      bus.teclado_pi   = 4'(key);
      bus.key_valid_pi = valid;
      bus.rd_addr_pi   = (rd < 0) ? 3'($urandom_range(0, 7)) : 3'(rd);
      e.rd = hist_read(int'(bus.rd_addr_pi));
      if (valid) model_step(key, bus.switch_pi);
      e.disp = exp_display();
      e.lop  = (m_mode == MB);
      e.lerr = (m_mode == ME);
      e.cnt  = hist_count();
      q.push_back(e);
   endtask

   task automatic seq(input string s);
      byte c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (c >= "0" && c <= "9") cycle(int'(c - "0"), 1'b1, -1);
         else cycle(int'(c - "A") + 10, 1'b1, -1);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 1'b0, -1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_display"}, int'(bus.display_po), 0);
      check({tag, "_led_op"}, int'(bus.led_op_po), 0);
      check({tag, "_led_err"}, int'(bus.led_error_po), 0);
      check({tag, "_count"}, int'(bus.hist_count_po), 0);
      check({tag, "_rd"}, int'(bus.rd_data_po), 0);
   endtask

   // Mid-cycle reset must clear outputs before the next clock edge
   task automatic reset_mid();
      @(negedge clk);
      bus.key_valid_pi = 1'b0;
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("display", int'(bus.display_po), e.disp);
            check("led_op", int'(bus.led_op_po), e.lop);
            check("led_err", int'(bus.led_error_po), e.lerr);
            check("hist_count", int'(bus.hist_count_po), e.cnt);
            check("rd_data", int'(bus.rd_data_po), e.rd);
         end
      end
   end

   initial begin : stim
      int r;
      rst = 1'b1;
      bus.teclado_pi   = '0;
      bus.key_valid_pi = 1'b0;
      bus.switch_pi    = 1'b1;
      bus.rd_addr_pi   = '0;
      model_reset();
      #12 check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      seq("2B3A");
      cycle(0, 1'b0, 0);
      idle(1);
      seq("F250B10A");
      seq("33");
      seq("F");
      seq("F256");
      seq("F3C5A");
      seq("F7BA");
      seq("F4B3AD6A");
      idle(1);
      bus.switch_pi = 1'b0;
      seq("F4B3AD");
      idle(1);
      seq("6A");
      bus.switch_pi = 1'b1;
      seq("F5BC2A");
      cycle(7, 1'b0, -1);
      idle(1);

      seq("F");
      for (int k = 1; k <= 9; k++) begin
         cycle(0, 1'b1, -1);
         cycle(11, 1'b1, -1);
         cycle(k, 1'b1, -1);
         cycle(10, 1'b1, -1);
      end
      cycle(0, 1'b0, 0);
      cycle(0, 1'b0, 1);
      cycle(0, 1'b0, 7);
      idle(1);

      seq("1B");
      reset_mid();
      idle(2);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0) bus.switch_pi = 1'($urandom);
         r = $urandom_range(0, 99);
         if (r < 50)      cycle($urandom_range(0, 9), 1'b1, -1);
         else if (r < 75) cycle($urandom_range(11, 14), 1'b1, -1);
         else if (r < 87) cycle(10, 1'b1, -1);
         else if (r < 93) cycle(15, 1'b1, -1);
         else             cycle($urandom_range(0, 15), 1'b0, -1);
      end
      idle(3);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d pending expected 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
